// File: rtl/aes_serial_master.sv
// -----------------------------------------------------------------------------
// aes_serial_master
//
// Host-side bridge for one serial Encrypt/Decrypt core. A job is a 128-bit
// data block plus a 128-bit key, accepted on a valid/ready handshake. Both
// are streamed LSB first into the core over cs/miso (data bits first, then
// key bits). The 128-bit result is then shifted back in from mosi and held on
// a valid/ready output until it is taken.
//
// Frame on the link (defaults LOAD_LEAD = GAP = READ_LEAD = 1):
//   cs high LOAD_LEAD+256 cycles  (LOAD_LEAD lead cycles with miso=0, then 256 bits)
//   cs low  GAP cycles
//   cs high READ_LEAD+128 cycles  (READ_LEAD lead cycles, then 128 mosi samples)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   data_in/key_in valid         in_ready   idle, job accepted
//   data_in    128-bit block                key_in     128-bit key
//   out_valid  data_out valid               out_ready  consumer takes data_out
//   data_out   128-bit result
//   cs, miso   chip select and serial data to the core
//   mosi       serial result from the core
//   job_cnt    completed-job counter (only with AES_MASTER_CNT_EN)
//
// Build option: define AES_MASTER_CNT_EN to add the 16-bit job_cnt output,
// which counts output handshakes and wraps at 16'hFFFF.
//
// LOAD_LEAD, GAP and READ_LEAD are expected to be at least 1.
// -----------------------------------------------------------------------------
module aes_serial_master #(
    parameter int unsigned LOAD_LEAD = 1,
    parameter int unsigned GAP       = 1,
    parameter int unsigned READ_LEAD = 1,
    parameter int unsigned CNT_W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         cs,
    output logic         miso,
`ifdef AES_MASTER_CNT_EN
    output logic [15:0]  job_cnt,
`endif
    input  logic         mosi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LLEAD,
        S_LOAD,
        S_GAP,
        S_RLEAD,
        S_READ,
        S_DONE
    } state_e;

    // Terminal counts of each timed state; the counter restarts at 0 on
    // every state entry, so it never needs to wrap.
    localparam logic [CNT_W-1:0] LLEAD_LAST = CNT_W'(LOAD_LEAD - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(255);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] RLEAD_LAST = CNT_W'(READ_LEAD - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(127);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [255:0]       sr_q, sr_d;        // {key, data}, shifted right as bits go out
    logic [127:0]       res_q, res_d;      // result, filled from the MSB end
    logic [127:0]       data_out_q, data_out_d;
    logic               cs_q, cs_d;
    logic               miso_q, miso_d;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        res_d      = res_q;
        data_out_d = data_out_q;
        cs_d       = cs_q;
        miso_d     = miso_q;

        case (state_q)
            S_IDLE: begin
                // Being in IDLE is exactly in_ready, so in_valid alone accepts.
                if (in_valid) begin
                    sr_d    = {key_in, data_in};
                    cs_d    = 1'b1;
                    miso_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_LLEAD;
                end
            end
            S_LLEAD: begin
                if (cnt_q == LLEAD_LAST) begin
                    miso_d  = sr_q[0];
                    sr_d    = {1'b0, sr_q[255:1]};
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOAD: begin
                // cnt_q is the index of the bit currently on miso.
                if (cnt_q == LOAD_LAST) begin
                    cs_d    = 1'b0;
                    miso_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    miso_d = sr_q[0];
                    sr_d   = {1'b0, sr_q[255:1]};
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cs_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RLEAD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RLEAD: begin
                if (cnt_q == RLEAD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_READ: begin
                // Shifting in at the top leaves the first-received bit at [0]
                // after 128 samples.
                res_d = {mosi, res_q[127:1]};
                if (cnt_q == READ_LAST) begin
                    data_out_d = {mosi, res_q[127:1]};
                    cs_d       = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    // NOTE: the wide shift/result registers are reset along with the control
    // flops; a reset mid-job must leave no partial data on data_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            res_q      <= '0;
            data_out_q <= '0;
            cs_q       <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            res_q      <= res_d;
            data_out_q <= data_out_d;
            cs_q       <= cs_d;
            miso_q     <= miso_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign data_out  = data_out_q;
    assign cs        = cs_q;
    assign miso      = miso_q;

`ifdef AES_MASTER_CNT_EN
    logic [15:0] job_cnt_q, job_cnt_d;

    always_comb begin
        job_cnt_d = job_cnt_q;
        if (out_valid && out_ready) begin
            job_cnt_d = job_cnt_q + 16'd1;    // wraps naturally at 16'hFFFF
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            job_cnt_q <= '0;
        end else begin
            job_cnt_q <= job_cnt_d;
        end
    end

    assign job_cnt = job_cnt_q;
`endif

endmodule
